// File: rtl/render_stream_source.sv
// rtl/render_stream_source.sv - head-of-chain beat generator: raster scan beats with FIFO-buffered programming beats at frame boundaries
module render_stream_source #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] bg_color,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_stage,
    input  logic [11:0] cmd_reg,
    input  logic [11:0] cmd_data,
    output logic        program_out,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic [11:0] data_out,
    output logic        frame_start,
    output logic        line_start
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [11:0]   X_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0]   Y_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROGRAM = 2'd1,
        ST_SCAN    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [35:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [11:0]    x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [11:0]    bg_q, bg_d;
    logic           program_q, program_d;
    logic [11:0]    x_q, x_d, y_q, y_d, data_q, data_d;
    logic           frame_start_q, frame_start_d;
    logic           line_start_q, line_start_d;

    logic           push, pop, frame_end, last_pop, at_origin;
    logic [35:0]    head;

    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == ST_PROGRAM) && (count_q != '0);
    assign head      = fifo_mem_q[rd_ptr_q];
    assign at_origin = (x_cnt_q == 12'd0) && (y_cnt_q == 12'd0);
    assign frame_end = (state_q == ST_SCAN) && (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);
    // A push landing alongside the final pop keeps the drain going one more beat.
    assign last_pop  = (count_q == '0) || ((count_q == CW'(1)) && !push);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_stage, cmd_reg, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            bg_q          <= '0;
            program_q     <= 1'b1;
            x_q           <= 12'hFFF;
            y_q           <= 12'hFFF;
            data_q        <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            bg_q          <= bg_d;
            program_q     <= program_d;
            x_q           <= x_d;
            y_q           <= y_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = (count_q != '0) ? ST_PROGRAM : ST_SCAN;
                end
            end
            ST_PROGRAM: begin
                if (last_pop) begin
                    state_d = enable ? ST_SCAN : ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (frame_end) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (count_q != '0) begin
                        state_d = ST_PROGRAM;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters rest at (0,0) outside SCAN, so every frame starts at the origin.
    always_comb begin
        program_d     = 1'b1;
        x_d           = 12'hFFF;
        y_d           = 12'hFFF;
        data_d        = '0;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        bg_d          = bg_q;
        case (state_q)
            ST_PROGRAM: begin
                if (pop) begin
                    x_d    = head[35:24];
                    y_d    = head[23:12];
                    data_d = head[11:0];
                end
            end
            ST_SCAN: begin
                program_d     = 1'b0;
                x_d           = x_cnt_q;
                y_d           = y_cnt_q;
                frame_start_d = at_origin;
                line_start_d  = (x_cnt_q == 12'd0);
                if (at_origin) begin
                    bg_d   = bg_color;
                    data_d = bg_color;
                end else begin
                    data_d = bg_q;
                end
                if (x_cnt_q == X_LAST) begin
                    x_cnt_d = '0;
                    y_cnt_d = (y_cnt_q == Y_LAST) ? 12'd0 : y_cnt_q + 12'd1;
                end else begin
                    x_cnt_d = x_cnt_q + 12'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign program_out = program_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign data_out    = data_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
endmodule

// File: tb/tb_render_stream_source.sv
// tb/tb_render_stream_source.sv - randomized and directed bench for render_stream_source against a queue-based beat model
module tb_render_stream_source;
    localparam int H = 4;
    localparam int V = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] bg_color = '0;
    logic        cmd_valid = 1'b0;
    logic [11:0] cmd_stage = '0, cmd_reg = '0, cmd_data = '0;
    logic        cmd_ready, program_out, frame_start, line_start;
    logic [11:0] x_out, y_out, data_out;

    render_stream_source #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bg_color(bg_color),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_stage(cmd_stage),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data), .program_out(program_out),
        .x_out(x_out), .y_out(y_out), .data_out(data_out),
        .frame_start(frame_start), .line_start(line_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [11:0] s;
        logic [11:0] r;
        logic [11:0] d;
    } cmd_t;

    cmd_t        mq[$];
    int          mode;   // 0 waiting, 1 draining commands, 2 scanning a frame
    int          pos;    // linear pixel index within the frame
    logic [11:0] bg_lat;
    logic        e_prog, e_fs, e_ls;
    logic [11:0] e_x, e_y, e_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int   pre;
        bit   push;
        cmd_t c;
        {e_prog, e_x, e_y, e_d, e_fs, e_ls} = {1'b1, 12'hFFF, 12'hFFF, 12'h000, 2'b00};
        if (!rst_n) begin
            mq.delete();
            mode   = 0;
            pos    = 0;
            bg_lat = '0;
            return;
        end
        pre  = mq.size();
        push = cmd_valid && (pre < D);
        case (mode)
            0: if (enable) mode = (pre > 0) ? 1 : 2;
            1: begin
                if (pre > 0) begin
                    c = mq.pop_front();
                    e_x = c.s; e_y = c.r; e_d = c.d;
                end
                if (push) mq.push_back({cmd_stage, cmd_reg, cmd_data});
                push = 1'b0;
                if (mq.size() == 0) mode = enable ? 2 : 0;
            end
            default: begin
                e_prog = 1'b0;
                e_x    = 12'(pos % H);
                e_y    = 12'(pos / H);
                if (pos == 0) bg_lat = bg_color;
                e_d    = bg_lat;
                e_fs   = (pos == 0);
                e_ls   = (pos % H == 0);
                pos++;
                if (pos == H * V) begin
                    pos = 0;
                    if (!enable) mode = 0;
                    else if (pre > 0) mode = 1;
                end
            end
        endcase
        if (push) mq.push_back({cmd_stage, cmd_reg, cmd_data});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("beat", 64'({program_out, x_out, y_out, data_out, frame_start, line_start}),
            64'({e_prog, e_x, e_y, e_d, e_fs, e_ls}));
        chk("cmd_ready", 64'(cmd_ready), 64'(mq.size() < D));
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, 64'({program_out, x_out, y_out, data_out, frame_start, line_start, cmd_ready}),
            64'({1'b1, 12'hFFF, 12'hFFF, 12'h000, 1'b0, 1'b0, 1'b1}));
    endtask

    initial begin
        int acc, got, w;
        logic rdy;
        model_step();
        repeat (2) @(negedge clk);
        chk_reset_vals("reset_values");
        rst_n = 1'b1;

        // Free-running scan, empty FIFO
        bg_color = 12'hABC;
        enable   = 1'b1;
        tick();
        chk("t1_decision_null", 64'(program_out), 64'(1));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_scan_beat", 64'({program_out, x_out, y_out, data_out, line_start, frame_start}),
                64'({1'b0, 12'(i % 4), 12'(i / 4), 12'hABC, (i % 4 == 0), (i == 0)}));
        end
        tick();
        chk("t1_no_gap", 64'({program_out, x_out, y_out, frame_start}), 64'({1'b0, 24'h0, 1'b1}));
        enable = 1'b0;
        repeat (10) tick();
        chk("t1_idle_null", 64'({program_out, x_out, y_out, data_out}), 64'({1'b1, 12'hFFF, 12'hFFF, 12'h000}));

        // Two commands queued in IDLE
        cmd_valid = 1'b1;
        {cmd_stage, cmd_reg, cmd_data} = {12'd0, 12'd2, 12'h010};
        tick();
        {cmd_stage, cmd_reg, cmd_data} = {12'd1, 12'd4, 12'hF00};
        tick();
        cmd_valid = 1'b0;
        enable    = 1'b1;
        tick();
        chk("t2_decision_null", 64'(program_out && x_out == 12'hFFF), 64'(1));
        tick();
        chk("t2_prog0", 64'({program_out, x_out, y_out, data_out}), 64'({1'b1, 12'd0, 12'd2, 12'h010}));
        tick();
        chk("t2_prog1", 64'({program_out, x_out, y_out, data_out}), 64'({1'b1, 12'd1, 12'd4, 12'hF00}));
        tick();
        chk("t2_scan_origin", 64'({program_out, x_out, y_out, frame_start}), 64'({1'b0, 24'h0, 1'b1}));

        // Five pushes mid-frame against a 4-deep FIFO
        acc = 0;
        got = 0;
        for (int k = 0; k < 40 && got < 5; k++) begin
            cmd_valid = (acc < 5);
            {cmd_stage, cmd_reg, cmd_data} = {12'(acc), 12'd4, 12'(12'h100 + acc)};
            rdy = cmd_ready;
            tick();
            if (cmd_valid && rdy) begin
                acc++;
                if (acc == 4) chk("t3_ready_low_when_full", 64'(cmd_ready), 64'(0));
            end
            if (program_out && x_out != 12'hFFF) begin
                chk("t3_drain_order", 64'(data_out), 64'(12'h100 + got));
                got++;
            end
        end
        cmd_valid = 1'b0;
        chk("t3_all_drained", 64'(got), 64'(5));

        // Drop enable at (1,1)
        w = 0;
        while (!(e_prog == 1'b0 && e_x == 12'd1 && e_y == 12'd1) && w < 40) begin
            tick();
            w++;
        end
        chk("t4_reached_1_1", 64'(w < 40), 64'(1));
        enable = 1'b0;
        tick();
        chk("t4_beat_2_1", 64'({program_out, x_out, y_out}), 64'({1'b0, 12'd2, 12'd1}));
        tick();
        chk("t4_beat_3_1", 64'({program_out, x_out, y_out}), 64'({1'b0, 12'd3, 12'd1}));
        tick();
        chk("t4_null_a", 64'({program_out, x_out, y_out, data_out}), 64'({1'b1, 12'hFFF, 12'hFFF, 12'h000}));
        tick();
        chk("t4_null_b", 64'({program_out, x_out, y_out, data_out}), 64'({1'b1, 12'hFFF, 12'hFFF, 12'h000}));

        // Reset during PROGRAM with entries still queued
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            {cmd_stage, cmd_reg, cmd_data} = {12'(k), 12'd1, 12'(12'h200 + k)};
            tick();
        end
        cmd_valid = 1'b0;
        enable    = 1'b1;
        tick();
        tick();
        chk("t5_first_pop", 64'({program_out, x_out, data_out}), 64'({1'b1, 12'd0, 12'h200}));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t5_async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_post_reset_null", 64'({program_out, x_out}), 64'({1'b1, 12'hFFF}));
        tick();
        chk("t5_scan_not_program", 64'({program_out, x_out, y_out, data_out}), 64'({1'b0, 12'd0, 12'd0, 12'hABC}));

        // Background change mid-frame
        tick();
        bg_color = 12'h123;
        tick();
        chk("t6_bg_held", 64'({x_out, data_out}), 64'({12'd2, 12'hABC}));
        w = 0;
        do begin
            tick();
            w++;
        end while (!e_fs && w < 20);
        chk("t6_bg_new_at_origin", 64'({frame_start, data_out}), 64'({1'b1, 12'h123}));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            enable    = ($urandom_range(0, 15) != 0);
            cmd_valid = ($urandom_range(0, 5) == 0);
            cmd_stage = 12'($urandom_range(0, 7));
            cmd_reg   = 12'($urandom_range(0, 4));
            cmd_data  = 12'($urandom);
            if ($urandom_range(0, 9) == 0) bg_color = 12'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
